// File: rtl/control_sequencer.sv
// control_sequencer: multicycle main control FSM producing the state code consumed by control decode.
// Optional feature macro: CONTROL_SEQ_PERF_EN adds free-running cycle/instruction counters.
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   opcode       in   IR[31:26], valid from the cycle after INSTRUCTION_FETCH completes
//   fetch_opcode in   memory read-data[31:26], valid in INSTRUCTION_FETCH when mem_ready=1
//   mem_ready    in   memory access completes this cycle
//   state        out  registered 4-bit state code
//   instr_done   out  pulse in the final state of each instruction
//   illegal_op   out  registered pulse after an undecodable opcode or unused state code
//   halted       out  high while in HALT
//   cycle_count  out  (CONTROL_SEQ_PERF_EN) cycles spent outside HALT, wraps
//   instr_count  out  (CONTROL_SEQ_PERF_EN) completed instructions, wraps
module control_sequencer #(
  parameter logic [5:0] JUMP_OPCODE = 6'b110000,
  parameter logic [5:0] IMM_OPCODE  = 6'b110001,
  parameter logic [5:0] HALT_OPCODE = 6'b111111
`ifdef CONTROL_SEQ_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] fetch_opcode,
  input  logic       mem_ready,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       halted
`ifdef CONTROL_SEQ_PERF_EN
  , output logic [PERF_W-1:0] cycle_count
  , output logic [PERF_W-1:0] instr_count
`endif
);
  typedef enum logic [3:0] {
    INSTRUCTION_FETCH    = 4'd0,
    REGISTER_FETCH       = 4'd1,
    ALU_R3               = 4'd2,
    ALU_RI3              = 4'd3,
    ALU4                 = 4'd4,
    BRANCH3              = 4'd5,
    MEMORY_REF3          = 4'd6,
    LOAD4                = 4'd7,
    LOAD5                = 4'd8,
    STORE4               = 4'd9,
    JUMP3                = 4'd10,
    IMMEDIATE_INJECTION2 = 4'd11,
    HALT                 = 4'd12
  } stateT;
  stateT curState;
  assign state = curState;
  assign halted = curState == HALT;
  // A store completes in the same cycle its memory handshake does.
  assign instr_done = (curState inside {ALU4, BRANCH3, JUMP3, IMMEDIATE_INJECTION2, LOAD5}) ||
                      (curState == STORE4 && mem_ready);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      curState <= INSTRUCTION_FETCH;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= 1'b0;
      case (curState)
        INSTRUCTION_FETCH: if (mem_ready) curState <= (fetch_opcode == IMM_OPCODE) ? IMMEDIATE_INJECTION2 : REGISTER_FETCH;
        REGISTER_FETCH: begin
          if (opcode[5:4] == 2'b00) curState <= ALU_R3;
          else if (opcode[5:4] == 2'b01) curState <= ALU_RI3;
          else if (opcode[5:3] == 3'b100) curState <= BRANCH3;
          else if (opcode[5:3] == 3'b101) curState <= MEMORY_REF3;
          else if (opcode == JUMP_OPCODE) curState <= JUMP3;
          else if (opcode == HALT_OPCODE) curState <= HALT;
          else begin
            // Includes IMM_OPCODE: it is only legal when seen at fetch.
            curState <= INSTRUCTION_FETCH;
            illegal_op <= 1'b1;
          end
        end
        ALU_R3, ALU_RI3: curState <= ALU4;
        MEMORY_REF3: curState <= opcode[2] ? STORE4 : LOAD4;
        LOAD4: if (mem_ready) curState <= LOAD5;
        STORE4: if (mem_ready) curState <= INSTRUCTION_FETCH;
        HALT: curState <= HALT;
        ALU4, BRANCH3, JUMP3, IMMEDIATE_INJECTION2, LOAD5: curState <= INSTRUCTION_FETCH;
        default: begin
          curState <= INSTRUCTION_FETCH;
          illegal_op <= 1'b1;
        end
      endcase
    end
  end
`ifdef CONTROL_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else if (curState != HALT) begin
      cycle_count <= cycle_count + PERF_W'(1);
      instr_count <= instr_count + PERF_W'(instr_done);
    end
  end
`endif
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench replaying per-cycle stimulus with expected FSM outputs.
module tb_control_sequencer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] fetch_opcode = '0;
  logic       mem_ready = 1'b0;
  logic [3:0] state;
  logic       instr_done, illegal_op, halted;
  int nRun = 0;
  int nFail = 0;
`ifdef CONTROL_SEQ_PERF_EN
  logic [3:0] cycle_count, instr_count;
  control_sequencer #(.PERF_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .fetch_opcode(fetch_opcode),
    .mem_ready(mem_ready), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .halted(halted),
    .cycle_count(cycle_count), .instr_count(instr_count));
`else
  control_sequencer dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .fetch_opcode(fetch_opcode),
    .mem_ready(mem_ready), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .halted(halted));
`endif
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fop;
    logic       mr;
    logic [3:0] st;
    logic       dn;
    logic       il;
    logic       hl;
  } stepT;
  stepT expQ[$];

  function automatic void add(input logic [5:0] op, input logic [5:0] fop, input logic mr,
                              input logic [3:0] st, input logic dn, input logic il, input logic hl);
    stepT s;
    s.op = op; s.fop = fop; s.mr = mr; s.st = st; s.dn = dn; s.il = il; s.hl = hl;
    expQ.push_back(s);
  endfunction

  task automatic test_reset();
    mem_ready = 1'b1;
    fetch_opcode = 6'b110001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nRun++;
    if ({state, instr_done, illegal_op, halted} !== 7'b0) begin
      nFail++;
      $display("FAIL reset: got state=%0d done=%b ill=%b halted=%b, expected all zero", state, instr_done, illegal_op, halted);
    end
`ifdef CONTROL_SEQ_PERF_EN
    nRun++;
    if ({cycle_count, instr_count} !== 8'h00) begin
      nFail++;
      $display("FAIL reset_counters: got cycles=%0d instrs=%0d, expected 0 0", cycle_count, instr_count);
    end
`endif
    mem_ready = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_alu();
    int k = 0;
    stepT s;
    add(6'o00, 6'o00, 1, 0, 0, 0, 0); add(6'o00, 6'o00, 1, 1, 0, 0, 0);
    add(6'o00, 6'o00, 1, 2, 0, 0, 0); add(6'o00, 6'o00, 1, 4, 1, 0, 0);
    add(6'o25, 6'o25, 1, 0, 0, 0, 0); add(6'o25, 6'o25, 1, 1, 0, 0, 0);
    add(6'o25, 6'o25, 1, 3, 0, 0, 0); add(6'o25, 6'o25, 1, 4, 1, 0, 0);
    add(6'o25, 6'o25, 0, 0, 0, 0, 0);
    while (expQ.size() != 0) begin
      s = expQ.pop_front();
      opcode = s.op; fetch_opcode = s.fop; mem_ready = s.mr;
      #1;
      nRun++;
      if ({state, instr_done, illegal_op, halted} !== {s.st, s.dn, s.il, s.hl}) begin
        nFail++;
        $display("FAIL alu step %0d: got state=%0d done=%b ill=%b halted=%b, expected state=%0d done=%b ill=%b halted=%b",
                 k, state, instr_done, illegal_op, halted, s.st, s.dn, s.il, s.hl);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_memory();
    int k = 0;
    stepT s;
    add(6'o50, 6'o50, 1, 0, 0, 0, 0); add(6'o50, 6'o50, 0, 1, 0, 0, 0);
    add(6'o50, 6'o50, 0, 6, 0, 0, 0); add(6'o50, 6'o50, 0, 7, 0, 0, 0);
    add(6'o50, 6'o50, 0, 7, 0, 0, 0); add(6'o50, 6'o50, 0, 7, 0, 0, 0);
    add(6'o50, 6'o50, 1, 7, 0, 0, 0); add(6'o50, 6'o50, 0, 8, 1, 0, 0);
    add(6'o54, 6'o54, 0, 0, 0, 0, 0); add(6'o54, 6'o54, 0, 0, 0, 0, 0);
    add(6'o54, 6'o54, 1, 0, 0, 0, 0); add(6'o54, 6'o54, 0, 1, 0, 0, 0);
    add(6'o54, 6'o54, 0, 6, 0, 0, 0); add(6'o54, 6'o54, 0, 9, 0, 0, 0);
    add(6'o54, 6'o54, 1, 9, 1, 0, 0); add(6'o54, 6'o54, 0, 0, 0, 0, 0);
    while (expQ.size() != 0) begin
      s = expQ.pop_front();
      opcode = s.op; fetch_opcode = s.fop; mem_ready = s.mr;
      #1;
      nRun++;
      if ({state, instr_done, illegal_op, halted} !== {s.st, s.dn, s.il, s.hl}) begin
        nFail++;
        $display("FAIL memory step %0d: got state=%0d done=%b ill=%b halted=%b, expected state=%0d done=%b ill=%b halted=%b",
                 k, state, instr_done, illegal_op, halted, s.st, s.dn, s.il, s.hl);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_control();
    int k = 0;
    stepT s;
    add(6'o00, 6'o61, 1, 0, 0, 0, 0); add(6'o00, 6'o61, 0, 11, 1, 0, 0);
    add(6'o62, 6'o62, 1, 0, 0, 0, 0); add(6'o62, 6'o62, 1, 1, 0, 0, 0);
    add(6'o62, 6'o62, 0, 0, 0, 1, 0); add(6'o61, 6'o00, 1, 0, 0, 0, 0);
    add(6'o61, 6'o00, 1, 1, 0, 0, 0); add(6'o60, 6'o60, 1, 0, 0, 1, 0);
    add(6'o60, 6'o60, 1, 1, 0, 0, 0); add(6'o60, 6'o60, 1, 10, 1, 0, 0);
    add(6'o41, 6'o41, 1, 0, 0, 0, 0); add(6'o41, 6'o41, 1, 1, 0, 0, 0);
    add(6'o41, 6'o41, 1, 5, 1, 0, 0); add(6'o41, 6'o41, 0, 0, 0, 0, 0);
    while (expQ.size() != 0) begin
      s = expQ.pop_front();
      opcode = s.op; fetch_opcode = s.fop; mem_ready = s.mr;
      #1;
      nRun++;
      if ({state, instr_done, illegal_op, halted} !== {s.st, s.dn, s.il, s.hl}) begin
        nFail++;
        $display("FAIL control step %0d: got state=%0d done=%b ill=%b halted=%b, expected state=%0d done=%b ill=%b halted=%b",
                 k, state, instr_done, illegal_op, halted, s.st, s.dn, s.il, s.hl);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    stepT s;
    add(6'o50, 6'o50, 1, 0, 0, 0, 0); add(6'o50, 6'o50, 0, 1, 0, 0, 0);
    add(6'o50, 6'o50, 0, 6, 0, 0, 0); add(6'o50, 6'o50, 0, 7, 0, 0, 0);
    while (expQ.size() != 0) begin
      s = expQ.pop_front();
      opcode = s.op; fetch_opcode = s.fop; mem_ready = s.mr;
      #1;
      nRun++;
      if ({state, instr_done, illegal_op, halted} !== {s.st, s.dn, s.il, s.hl}) begin
        nFail++;
        $display("FAIL reset_mid step %0d: got state=%0d done=%b ill=%b halted=%b, expected state=%0d done=%b ill=%b halted=%b",
                 k, state, instr_done, illegal_op, halted, s.st, s.dn, s.il, s.hl);
      end
      k++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    nRun++;
    if ({state, instr_done} !== 5'b0) begin
      nFail++;
      $display("FAIL reset_mid_abandon: got state=%0d done=%b, expected state=0 done=0", state, instr_done);
    end
    mem_ready = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    nRun++;
    if (state !== 4'd0) begin
      nFail++;
      $display("FAIL reset_mid_hold: got state=%0d, expected 0", state);
    end
  endtask

  task automatic test_halt();
    int k = 0;
    stepT s;
    add(6'o77, 6'o77, 1, 0, 0, 0, 0); add(6'o77, 6'o77, 0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) add(6'($urandom), 6'($urandom), 1'($urandom), 12, 0, 0, 1);
    while (expQ.size() != 0) begin
      s = expQ.pop_front();
      opcode = s.op; fetch_opcode = s.fop; mem_ready = s.mr;
      #1;
      nRun++;
      if ({state, instr_done, illegal_op, halted} !== {s.st, s.dn, s.il, s.hl}) begin
        nFail++;
        $display("FAIL halt step %0d: got state=%0d done=%b ill=%b halted=%b, expected state=%0d done=%b ill=%b halted=%b",
                 k, state, instr_done, illegal_op, halted, s.st, s.dn, s.il, s.hl);
      end
      k++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    nRun++;
    if ({state, instr_done, illegal_op, halted} !== 7'b0) begin
      nFail++;
      $display("FAIL halt_async_reset: got state=%0d done=%b ill=%b halted=%b, expected all zero", state, instr_done, illegal_op, halted);
    end
    reset_n = 1'b1;
    #2;
  endtask

`ifdef CONTROL_SEQ_PERF_EN
  task automatic test_perf();
    int k = 0;
    stepT s;
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      add(6'o00, 6'o00, 1, 0, 0, 0, 0); add(6'o00, 6'o00, 1, 1, 0, 0, 0);
      add(6'o00, 6'o00, 1, 2, 0, 0, 0); add(6'o00, 6'o00, 1, 4, 1, 0, 0);
    end
    while (expQ.size() != 0) begin
      s = expQ.pop_front();
      opcode = s.op; fetch_opcode = s.fop; mem_ready = s.mr;
      #1;
      nRun++;
      if ({state, instr_done, illegal_op, halted} !== {s.st, s.dn, s.il, s.hl}) begin
        nFail++;
        $display("FAIL perf step %0d: got state=%0d done=%b ill=%b halted=%b, expected state=%0d done=%b ill=%b halted=%b",
                 k, state, instr_done, illegal_op, halted, s.st, s.dn, s.il, s.hl);
      end
      k++;
      @(posedge clk); #1;
    end
    nRun++;
    if ({cycle_count, instr_count} !== {4'd4, 4'd5}) begin
      nFail++;
      $display("FAIL perf_wrap: got cycles=%0d instrs=%0d, expected 4 5", cycle_count, instr_count);
    end
    add(6'o77, 6'o77, 1, 0, 0, 0, 0); add(6'o77, 6'o77, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(6'o77, 6'o77, 1, 12, 0, 0, 1);
    while (expQ.size() != 0) begin
      s = expQ.pop_front();
      opcode = s.op; fetch_opcode = s.fop; mem_ready = s.mr;
      #1;
      nRun++;
      if ({state, instr_done, illegal_op, halted} !== {s.st, s.dn, s.il, s.hl}) begin
        nFail++;
        $display("FAIL perf_halt step %0d: got state=%0d done=%b ill=%b halted=%b, expected state=%0d done=%b ill=%b halted=%b",
                 k, state, instr_done, illegal_op, halted, s.st, s.dn, s.il, s.hl);
      end
      k++;
      @(posedge clk); #1;
    end
    nRun++;
    if ({cycle_count, instr_count} !== {4'd6, 4'd5}) begin
      nFail++;
      $display("FAIL perf_freeze: got cycles=%0d instrs=%0d, expected 6 5", cycle_count, instr_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_memory();
    test_control();
    test_reset_mid();
    test_halt();
`ifdef CONTROL_SEQ_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end
endmodule
